// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID register: owns the PC, drives the 1-cycle-latency
// inst SRAM, applies ID redirects after the delay slot and MEM exception redirects.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'hBFC00000,
   parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch,
   input  logic [31:0] branchAddr,
   input  logic        Jump,
   input  logic [31:0] jumpAddr,
   input  logic        JumpV,
   input  logic [31:0] jumpVAddr,
   input  logic        exc_redirect,
   input  logic [31:0] exc_pc,
   output logic        inst_sram_en,
   output logic [31:0] inst_sram_addr,
   input  logic [31:0] inst_sram_rdata,
   output logic [31:0] IF_ID_instr,
   output logic [31:0] IF_ID_PCout,
   output logic        IF_ID_valid,
   output logic        IF_ADEL_EXP
);

   typedef enum logic [1:0] {BOOT, RUN, HOLD} st_t;

   st_t         st_reg;
   logic [31:0] pc_reg;
   logic [31:0] buf_reg;
   logic        pend_reg;
   logic [31:0] tgt_reg;

   logic [31:0] next_pc;
   logic        redir;
   logic [31:0] redir_tgt;
   logic        presenting;
   logic        advance;
   logic        misaligned;
   logic [31:0] addr_next;

   assign next_pc    = pend_reg ? tgt_reg : pc_reg + 32'd4;
   assign redir      = JumpV | Jump | branch;
   assign redir_tgt  = JumpV ? jumpVAddr : (Jump ? jumpAddr : branchAddr);
   assign presenting = (st_reg == RUN) || (st_reg == HOLD);
   assign advance    = presenting && !stall;
   assign misaligned = (pc_reg[1:0] != 2'b00);

   always_comb begin
      inst_sram_en = 1'b0;
      addr_next    = next_pc;
      IF_ID_instr  = NOP_INSTR;
      IF_ID_PCout  = pc_reg;
      IF_ID_valid  = 1'b0;
      IF_ADEL_EXP  = 1'b0;
      if (rst) begin
         IF_ID_PCout = RESET_PC;
      end else if (exc_redirect) begin
         // The fetch that was in flight is killed; refetch from the handler.
         inst_sram_en = 1'b1;
         addr_next    = exc_pc;
      end else if (st_reg == BOOT) begin
         inst_sram_en = 1'b1;
         addr_next    = RESET_PC;
      end else if (presenting) begin
         IF_ID_valid  = 1'b1;
         inst_sram_en = !stall;
         if (misaligned) begin
            IF_ADEL_EXP = 1'b1;
         end else begin
            IF_ID_instr = (st_reg == HOLD) ? buf_reg : inst_sram_rdata;
         end
      end
   end

   assign inst_sram_addr = {addr_next[31:2], 2'b00};

   always_ff @(posedge clk) begin
      if (rst) begin
         st_reg   <= BOOT;
         pc_reg   <= RESET_PC;
         pend_reg <= 1'b0;
         buf_reg  <= 32'h0;
         tgt_reg  <= 32'h0;
      end else if (exc_redirect) begin
         st_reg   <= RUN;
         pc_reg   <= exc_pc;
         pend_reg <= 1'b0;
      end else if (st_reg == BOOT) begin
         st_reg <= RUN;
         pc_reg <= RESET_PC;
      end else if (advance) begin
         // The fetch issued now is the delay slot; a captured target goes out next step.
         st_reg <= RUN;
         pc_reg <= next_pc;
         if (redir) begin
            pend_reg <= 1'b1;
            tgt_reg  <= redir_tgt;
         end else if (pend_reg) begin
            pend_reg <= 1'b0;
         end
      end else if (st_reg == RUN) begin
         // SRAM data is not re-read while stalled, so keep a copy.
         buf_reg <= inst_sram_rdata;
         st_reg  <= HOLD;
      end
   end

endmodule
